// File: rtl/elevator_pkg.sv
// Shared constants and encodings for the elevator scheduler.
// Imported by the scheduler top and its call look-ahead helper.
package elevator_pkg;

    localparam int NFLOORS = 8;
    localparam int FLOOR_W = 3;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int ST_UP     = 3;
    localparam int ST_DOWN   = 2;
    localparam int ST_OPEN   = 1;
    localparam int ST_CLOSED = 0;

endpackage

// File: rtl/elevator_scheduler_call_lookahead.sv
// Summarises the pending calls relative to one floor and one travel direction.
// Purely combinational; the scheduler uses one copy for the current floor and one for the next.
module call_lookahead
    import elevator_pkg::*;
(
    input  logic [NFLOORS-1:0] up_pend,
    input  logic [NFLOORS-1:0] down_pend,
    input  logic [NFLOORS-1:0] car_pend,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               dir,
    output logic               above,
    output logic               below,
    output logic               here_any,
    output logic               here_dir,
    output logic               beyond_in_dir
);

    logic [NFLOORS-1:0] any_pend;

    always_comb begin
        any_pend = up_pend | down_pend | car_pend;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i > int'(floor)) above = above | any_pend[i];
            if (i < int'(floor)) below = below | any_pend[i];
        end
        here_any      = any_pend[floor];
        here_dir      = (dir == DIR_UP) ? up_pend[floor] : down_pend[floor];
        beyond_in_dir = (dir == DIR_UP) ? above : below;
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator sequencer: latches calls, picks direction, steps floors on ticks, times the door.
// Every output comes straight from a flop.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NFLOORS-1:0] up_req,
    input  logic [NFLOORS-1:0] down_req,
    input  logic [NFLOORS-1:0] car_req,
    input  logic               door_open_btn,
    input  logic               door_close_btn,
    output logic [FLOOR_W-1:0] floor,
    output logic [CNT_W-1:0]   countdown,
    output logic [3:0]         status,
    output logic [NFLOORS-1:0] up_pending,
    output logic [NFLOORS-1:0] down_pending,
    output logic [NFLOORS-1:0] car_pending,
    output logic               nextup,
    output logic               nextdown
);

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_TICKS);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NFLOORS-1:0] up_q, up_d, down_q, down_d, car_q, car_d;
    logic [3:0]         status_q, status_d;
    logic               nextup_q, nextup_d, nextdown_q, nextdown_d;

    logic               cur_above, cur_below, cur_any, cur_dir_hit, cur_beyond;
    logic               nxt_above, nxt_below, nxt_any, nxt_dir_hit, nxt_beyond;
    logic [FLOOR_W-1:0] nxt_floor;

    logic [NFLOORS-1:0] clr_up, clr_down, clr_car;
    logic               enter_door, ent_keep, reload;
    logic [FLOOR_W-1:0] ent_floor;
    logic               req_in_dir, req_opp, opp_pend;

    assign nxt_floor = (dir_q == DIR_UP)
                     ? ((floor_q == FLOOR_W'(NFLOORS - 1)) ? floor_q : floor_q + 1'b1)
                     : ((floor_q == '0) ? floor_q : floor_q - 1'b1);

    call_lookahead u_cur (
        .up_pend(up_q), .down_pend(down_q), .car_pend(car_q),
        .floor(floor_q), .dir(dir_q),
        .above(cur_above), .below(cur_below), .here_any(cur_any),
        .here_dir(cur_dir_hit), .beyond_in_dir(cur_beyond)
    );

    call_lookahead u_nxt (
        .up_pend(up_q), .down_pend(down_q), .car_pend(car_q),
        .floor(nxt_floor), .dir(dir_q),
        .above(nxt_above), .below(nxt_below), .here_any(nxt_any),
        .here_dir(nxt_dir_hit), .beyond_in_dir(nxt_beyond)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dir_q      <= DIR_UP;
            floor_q    <= '0;
            cnt_q      <= '0;
            up_q       <= '0;
            down_q     <= '0;
            car_q      <= '0;
            status_q   <= 4'b0001;
            nextup_q   <= 1'b0;
            nextdown_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            floor_q    <= floor_d;
            cnt_q      <= cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
            car_q      <= car_d;
            status_q   <= status_d;
            nextup_q   <= nextup_d;
            nextdown_q <= nextdown_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        cnt_d      = cnt_q;
        clr_up     = '0;
        clr_down   = '0;
        clr_car    = '0;
        enter_door = 1'b0;
        ent_keep   = 1'b0;
        ent_floor  = floor_q;
        reload     = 1'b0;
        req_in_dir = (dir_q == DIR_UP) ? up_req[floor_q]   : down_req[floor_q];
        req_opp    = (dir_q == DIR_UP) ? down_req[floor_q] : up_req[floor_q];
        opp_pend   = (dir_q == DIR_UP) ? down_q[floor_q]   : up_q[floor_q];

        case (state_q)
            S_IDLE: begin
                if (cur_any) begin
                    enter_door = 1'b1;
                    ent_keep   = cur_dir_hit | cur_beyond;
                end else if (cur_above && (dir_q == DIR_UP || !cur_below)) begin
                    state_d = S_MOVING;
                    dir_d   = DIR_UP;
                    cnt_d   = TRAVEL_LOAD;
                end else if (cur_below) begin
                    state_d = S_MOVING;
                    dir_d   = DIR_DOWN;
                    cnt_d   = TRAVEL_LOAD;
                end
            end
            S_MOVING: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(1)) begin
                        floor_d = nxt_floor;
                        if (car_q[nxt_floor] | nxt_dir_hit | (nxt_any & ~nxt_beyond)) begin
                            enter_door = 1'b1;
                            ent_floor  = nxt_floor;
                            ent_keep   = nxt_dir_hit | nxt_beyond;
                        end else if (!nxt_beyond) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = TRAVEL_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DOOR: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    // Calls answered by the open door are swallowed and restart the dwell.
                    clr_car[floor_q] = 1'b1;
                    if (cur_dir_hit | req_in_dir | cur_beyond) begin
                        if (dir_q == DIR_UP) clr_up[floor_q] = 1'b1;
                        else                 clr_down[floor_q] = 1'b1;
                    end else if (opp_pend | req_opp) begin
                        if (dir_q == DIR_UP) clr_down[floor_q] = 1'b1;
                        else                 clr_up[floor_q] = 1'b1;
                        dir_d = ~dir_q;
                    end
                    reload = car_req[floor_q] | (clr_up[floor_q] & up_req[floor_q])
                           | (clr_down[floor_q] & down_req[floor_q]);
                    if (door_close_btn)              cnt_d = '0;
                    else if (door_open_btn || reload) cnt_d = DOOR_LOAD;
                    else if (tick)                   cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_door) begin
            state_d            = S_DOOR;
            cnt_d              = DOOR_LOAD;
            clr_car[ent_floor] = 1'b1;
            // Keep direction if there is work in it, otherwise serve the opposite hall call.
            if ((dir_q == DIR_UP) == ent_keep) clr_up[ent_floor] = 1'b1;
            else                               clr_down[ent_floor] = 1'b1;
            if (!ent_keep) dir_d = ~dir_q;
        end

        up_d   = (up_q | up_req) & ~clr_up;
        down_d = (down_q | down_req) & ~clr_down;
        car_d  = (car_q | car_req) & ~clr_car;
    end

    always_comb begin
        status_d = '0;
        case (state_d)
            S_MOVING: status_d[(dir_d == DIR_UP) ? ST_UP : ST_DOWN] = 1'b1;
            S_DOOR:   status_d[ST_OPEN] = 1'b1;
            default:  status_d[ST_CLOSED] = 1'b1;
        endcase
        nextup_d   = (state_d == S_DOOR) && (dir_d == DIR_UP);
        nextdown_d = (state_d == S_DOOR) && (dir_d == DIR_DOWN);
    end

    assign floor        = floor_q;
    assign countdown    = cnt_q;
    assign status       = status_q;
    assign up_pending   = up_q;
    assign down_pending = down_q;
    assign car_pending  = car_q;
    assign nextup       = nextup_q;
    assign nextdown     = nextdown_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: a behavioural car model predicts every cycle,
// a monitor compares the DUT snapshot on each falling edge, directed scenarios add spot checks.
module tb_elevator_scheduler;

    localparam int TRAVEL = 2;
    localparam int DWELL  = 3;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

    logic       clk = 1'b0;
    logic       rst, tick, door_open_btn, door_close_btn;
    logic [7:0] up_req, down_req, car_req;
    logic [2:0] floor, countdown;
    logic [3:0] status;
    logic [7:0] up_pending, down_pending, car_pending;
    logic       nextup, nextdown;

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_q[$];

    int       m_mode, m_floor, m_cnt;
    bit       m_dir_up;
    bit [7:0] m_u, m_d, m_c;

    elevator_scheduler #(.TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DWELL)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .up_req(up_req), .down_req(down_req), .car_req(car_req),
        .door_open_btn(door_open_btn), .door_close_btn(door_close_btn),
        .floor(floor), .countdown(countdown), .status(status),
        .up_pending(up_pending), .down_pending(down_pending), .car_pending(car_pending),
        .nextup(nextup), .nextdown(nextdown)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit any_at(bit [7:0] u, bit [7:0] d, bit [7:0] c, int f);
        return u[f] | d[f] | c[f];
    endfunction

    function automatic bit any_above(bit [7:0] u, bit [7:0] d, bit [7:0] c, int f);
        for (int i = f + 1; i < 8; i++) if (u[i] | d[i] | c[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(bit [7:0] u, bit [7:0] d, bit [7:0] c, int f);
        for (int i = 0; i < f; i++) if (u[i] | d[i] | c[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [35:0] model_snap();
        logic [3:0] st;
        if (m_mode == M_IDLE)      st = 4'b0001;
        else if (m_mode == M_DOOR) st = 4'b0010;
        else                       st = m_dir_up ? 4'b1000 : 4'b0100;
        return {3'(m_floor), 3'(m_cnt), st, m_u, m_d, m_c,
                (m_mode == M_DOOR) && m_dir_up, (m_mode == M_DOOR) && !m_dir_up};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_cnt = 0; m_dir_up = 1'b1;
        m_u = '0; m_d = '0; m_c = '0;
    endtask

    // One clock of the car's rules, written from the calls' point of view.
    task automatic model_step(input bit [7:0] ur, input bit [7:0] dr, input bit [7:0] cr,
                              input bit tk, input bit ob, input bit cb);
        bit [7:0] u = m_u, d = m_d, c = m_c;
        bit [7:0] nu = m_u | ur, nd = m_d | dr, nc = m_c | cr;
        int  f = m_floor;
        bit  stop = 1'b0, beyond, cu, cd;
        case (m_mode)
            M_IDLE: begin
                if (any_at(u, d, c, f)) stop = 1'b1;
                else if (any_above(u, d, c, f) && (m_dir_up || !any_below(u, d, c, f))) begin
                    m_mode = M_MOVE; m_dir_up = 1'b1; m_cnt = TRAVEL;
                end else if (any_below(u, d, c, f)) begin
                    m_mode = M_MOVE; m_dir_up = 1'b0; m_cnt = TRAVEL;
                end
            end
            M_MOVE: if (tk) begin
                if (m_cnt > 1) m_cnt--;
                else begin
                    if (m_dir_up) f = (f < 7) ? f + 1 : f;
                    else          f = (f > 0) ? f - 1 : f;
                    m_floor = f;
                    beyond = m_dir_up ? any_above(u, d, c, f) : any_below(u, d, c, f);
                    if (c[f] || (m_dir_up ? u[f] : d[f]) || (any_at(u, d, c, f) && !beyond)) stop = 1'b1;
                    else if (!beyond) begin m_mode = M_IDLE; m_cnt = 0; end
                    else m_cnt = TRAVEL;
                end
            end
            default: begin
                if (m_cnt == 0) m_mode = M_IDLE;
                else begin
                    cu = 1'b0; cd = 1'b0;
                    nc[f] = 1'b0;
                    if (m_dir_up) begin
                        if (nu[f] || any_above(u, d, c, f)) cu = 1'b1;
                        else if (nd[f]) begin cd = 1'b1; m_dir_up = 1'b0; end
                    end else begin
                        if (nd[f] || any_below(u, d, c, f)) cd = 1'b1;
                        else if (nu[f]) begin cu = 1'b1; m_dir_up = 1'b1; end
                    end
                    if (cu) nu[f] = 1'b0;
                    if (cd) nd[f] = 1'b0;
                    if (cb) m_cnt = 0;
                    else if (ob || cr[f] || (cu && ur[f]) || (cd && dr[f])) m_cnt = DWELL;
                    else if (tk) m_cnt--;
                end
            end
        endcase
        if (stop) begin
            m_mode = M_DOOR; m_cnt = DWELL; nc[f] = 1'b0;
            if (m_dir_up) begin
                if (u[f] || any_above(u, d, c, f)) nu[f] = 1'b0;
                else begin nd[f] = 1'b0; m_dir_up = 1'b0; end
            end else begin
                if (d[f] || any_below(u, d, c, f)) nd[f] = 1'b0;
                else begin nu[f] = 1'b0; m_dir_up = 1'b1; end
            end
        end
        m_u = nu; m_d = nd; m_c = nc;
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("snapshot", {floor, countdown, status, up_pending, down_pending,
                               car_pending, nextup, nextdown}, e);
        end
    end

    task automatic step(input logic [7:0] ur, input logic [7:0] dr, input logic [7:0] cr,
                        input logic tk, input logic ob, input logic cb);
        up_req = ur; down_req = dr; car_req = cr;
        tick = tk; door_open_btn = ob; door_close_btn = cb;
        model_step(ur, dr, cr, tk, ob, cb);
        exp_q.push_back(model_snap());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_step();
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        up_req = '0; down_req = '0; car_req = '0;
        tick = 1'b0; door_open_btn = 1'b0; door_close_btn = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_floor", 36'(floor), 36'd0);
        check("rst_status", 36'(status), 36'b0001);
        check("rst_pending", 36'({up_pending, down_pending, car_pending}), 36'd0);
        model_reset();
        exp_q.push_back(model_snap());
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_door(input int max_steps);
        bit hit = 1'b0;
        for (int i = 0; i < max_steps && !hit; i++) begin
            step('0, '0, '0, (i % 2) == 0, 1'b0, 1'b0);
            hit = (status == 4'b0010);
        end
        check("door_reached", 36'(hit), 36'd1);
    endtask

    task automatic close_door();
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle_step();
    endtask

    initial begin
        bit reached;
        rst = 1'b0;
        #2;
        do_reset();

        // Car call to floor 5 from floor 0.
        step('0, '0, 8'h20, 1'b0, 1'b0, 1'b0);
        idle_step();
        check("move_up_status", 36'(status), 36'b1000);
        for (int i = 0; i < 10; i++) begin
            step('0, '0, '0, 1'b1, 1'b0, 1'b0);
            idle_step();
        end
        check("arrive5_floor", 36'(floor), 36'd5);
        check("arrive5_status", 36'(status), 36'b0010);
        check("arrive5_count", 36'(countdown), 36'd3);
        check("arrive5_car", 36'(car_pending), 36'd0);
        for (int i = 0; i < 3; i++) begin
            step('0, '0, '0, 1'b1, 1'b0, 1'b0);
            idle_step();
        end
        check("dwell_done", 36'(status), 36'b0001);

        // Collective sweep from floor 2: stop at 4 and 6 going up, 3 coming down.
        do_reset();
        step('0, '0, 8'h04, 1'b0, 1'b0, 1'b0);
        run_until_door(100);
        check("at2_floor", 36'(floor), 36'd2);
        close_door();
        step(8'h10, 8'h08, 8'h40, 1'b0, 1'b0, 1'b0);
        run_until_door(100);
        check("stop4_floor", 36'(floor), 36'd4);
        check("stop4_pend", 36'({up_pending, down_pending}), 36'h0008);
        close_door();
        run_until_door(100);
        check("stop6_floor", 36'(floor), 36'd6);
        check("stop6_nextdown", 36'(nextdown), 36'd1);
        close_door();
        run_until_door(100);
        check("stop3_floor", 36'(floor), 36'd3);
        check("stop3_down", 36'(down_pending), 36'd0);

        // Opposite hall call at an open door flips direction and restarts the dwell.
        do_reset();
        step(8'h10, '0, '0, 1'b0, 1'b0, 1'b0);
        run_until_door(100);
        check("door4_nextup", 36'(nextup), 36'd1);
        step('0, '0, '0, 1'b1, 1'b0, 1'b0);
        step('0, 8'h10, '0, 1'b0, 1'b0, 1'b0);
        check("flip_dirs", 36'({nextup, nextdown}), 36'b01);
        check("flip_down_clear", 36'(down_pending), 36'd0);
        check("flip_reload", 36'(countdown), 36'd3);

        // Door-open hold, then close together with a tick.
        for (int i = 0; i < 10; i++) step('0, '0, '0, (i % 2) == 0, 1'b1, 1'b0);
        check("hold_count", 36'(countdown), 36'd3);
        step('0, '0, '0, 1'b1, 1'b1, 1'b1);
        check("close_count", 36'(countdown), 36'd0);
        idle_step();
        check("close_idle", 36'(status), 36'b0001);

        // Hall call at the current floor opens without moving.
        do_reset();
        step(8'h01, '0, '0, 1'b0, 1'b0, 1'b0);
        idle_step();
        check("here_door", 36'({floor, status}), 36'({3'd0, 4'b0010}));

        // Top floor: no wrap.
        do_reset();
        step('0, '0, 8'h80, 1'b0, 1'b0, 1'b0);
        run_until_door(200);
        check("top_floor", 36'(floor), 36'd7);
        step('0, '0, 8'h80, 1'b0, 1'b0, 1'b0);
        check("top_car_swallowed", 36'(car_pending), 36'd0);
        close_door();
        for (int i = 0; i < 8; i++) step('0, '0, '0, (i % 2) == 0, 1'b0, 1'b0);
        check("top_stays", 36'({floor, status}), 36'({3'd7, 4'b0001}));

        // Reset while travelling between floors 3 and 4.
        do_reset();
        step('0, '0, 8'h40, 1'b0, 1'b0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step('0, '0, '0, (i % 2) == 0, 1'b0, 1'b0);
            reached = (floor == 3'd3);
        end
        check("reach3", 36'(reached), 36'd1);
        step('0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("mid_travel", 36'({status, countdown}), 36'({4'b1000, 3'd1}));
        do_reset();

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] ur, dr, cr, bitv;
            ur = '0; dr = '0; cr = '0;
            bitv = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ur = bitv;
                    1:       dr = bitv;
                    default: cr = bitv;
                endcase
            end
            step(ur, dr, cr, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0);
        end

        check("scoreboard_drained", 36'(exp_q.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
